// File: rtl/nx_msg_pkg.sv
// Shared mesh message definitions for the node encoder and decoder.
// Field layout MSB first: row, col, command, payload.
package nx_msg_pkg;

   localparam int unsigned NX_STREAM_WIDTH  = 32;
   localparam int unsigned NX_ROW_WIDTH     = 4;
   localparam int unsigned NX_COL_WIDTH     = 4;
   localparam int unsigned NX_CMD_WIDTH     = 2;
   localparam int unsigned NX_IDX_WIDTH     = 3;
   localparam int unsigned NX_DIR_WIDTH     = 2;
   localparam int unsigned NX_PAYLOAD_WIDTH = NX_STREAM_WIDTH - NX_ROW_WIDTH - NX_COL_WIDTH - NX_CMD_WIDTH;
   localparam int unsigned NX_SIG_PAD_WIDTH = NX_PAYLOAD_WIDTH - NX_IDX_WIDTH - 1;

   typedef enum logic [1:0] {
      NX_DIRX_NORTH = 2'd0,
      NX_DIRX_EAST  = 2'd1,
      NX_DIRX_SOUTH = 2'd2,
      NX_DIRX_WEST  = 2'd3
   } nx_direction_t;

   typedef enum logic [1:0] {
      NX_CMD_NOP       = 2'd0,
      NX_CMD_CONFIG    = 2'd1,
      NX_CMD_SIG_STATE = 2'd2,
      NX_CMD_RESERVED  = 2'd3
   } nx_command_t;

   typedef struct packed {
      logic [NX_ROW_WIDTH-1:0] row;
      logic [NX_COL_WIDTH-1:0] col;
      nx_command_t             command;
   } nx_header_t;

   typedef struct packed {
      logic [NX_IDX_WIDTH-1:0]     index;
      logic                        state;
      logic [NX_SIG_PAD_WIDTH-1:0] pad;
   } nx_sig_payload_t;

endpackage

// File: rtl/nx_msg_buffer.sv
// Two-entry FIFO with registered head; supports push and pop in the same cycle.
module nx_msg_buffer
   import nx_msg_pkg::*;
#(
   parameter int unsigned WIDTH = NX_STREAM_WIDTH + NX_DIR_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] entry_head;
   logic [WIDTH-1:0] entry_tail;
   logic [1:0]       count;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop_i && (count != 2'd0);
   assign do_push = push_i && ((count < 2'd2) || do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         entry_head <= '0;
         entry_tail <= '0;
         count      <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) entry_head <= data_i;
               else               entry_tail <= data_i;
               count <= count + 2'd1;
            end
            2'b01: begin
               entry_head <= entry_tail;
               entry_tail <= '0;
               count      <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the new entry lands behind whatever remains.
               if (count == 2'd1) begin
                  entry_head <= data_i;
               end else begin
                  entry_head <= entry_tail;
                  entry_tail <= data_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign data_o  = entry_head;
   assign count_o = count;

endmodule

// File: rtl/nx_msg_encoder.sv
// Outbound message port: builds local signal-state messages, routes them row-first
// and arbitrates fairly against the decoder bypass stream into a 2-entry buffer.
module nx_msg_encoder
   import nx_msg_pkg::*;
#(
   parameter int unsigned STREAM_WIDTH    = 32,
   parameter int unsigned ADDR_ROW_WIDTH  = 4,
   parameter int unsigned ADDR_COL_WIDTH  = 4,
   parameter int unsigned COMMAND_WIDTH   = 2,
   parameter int unsigned INPUT_IDX_WIDTH = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [ADDR_ROW_WIDTH-1:0]  node_row_i,
   input  logic [ADDR_COL_WIDTH-1:0]  node_col_i,
   input  logic [ADDR_ROW_WIDTH-1:0]  sig_row_i,
   input  logic [ADDR_COL_WIDTH-1:0]  sig_col_i,
   input  logic [INPUT_IDX_WIDTH-1:0] sig_index_i,
   input  logic                       sig_state_i,
   input  logic                       sig_valid_i,
   output logic                       sig_ready_o,
   input  logic [STREAM_WIDTH-1:0]    bypass_data_i,
   input  logic [1:0]                 bypass_dir_i,
   input  logic                       bypass_valid_i,
   output logic                       bypass_ready_o,
   output logic [STREAM_WIDTH-1:0]    msg_data_o,
   output logic [1:0]                 msg_dir_o,
   output logic                       msg_valid_o,
   input  logic                       msg_ready_i,
   output logic                       self_drop_o
);

   localparam int unsigned PAD_WIDTH = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH
                                       - COMMAND_WIDTH - INPUT_IDX_WIDTH - 1;
   localparam int unsigned ENTRY_WIDTH = STREAM_WIDTH + 2;

   localparam logic [0:0] GRANT_LOCAL  = 1'b0;
   localparam logic [0:0] GRANT_BYPASS = 1'b1;

   logic [0:0]              last_grant;
   logic [1:0]              count;
   logic                    space;
   logic                    grant_bypass;
   logic                    grant_local;
   logic                    local_acc;
   logic                    bypass_acc;
   logic                    self_hit;
   logic                    push;
   logic                    pop;
   logic [STREAM_WIDTH-1:0] local_msg;
   nx_direction_t           local_dir;
   logic [ENTRY_WIDTH-1:0]  push_entry;
   logic [ENTRY_WIDTH-1:0]  head_entry;

   assign local_msg = {sig_row_i, sig_col_i, COMMAND_WIDTH'(NX_CMD_SIG_STATE),
                       sig_index_i, sig_state_i, {PAD_WIDTH{1'b0}}};

   always_comb begin
      local_dir = NX_DIRX_WEST;
      if (sig_row_i < node_row_i)      local_dir = NX_DIRX_NORTH;
      else if (sig_row_i > node_row_i) local_dir = NX_DIRX_SOUTH;
      else if (sig_col_i > node_col_i) local_dir = NX_DIRX_EAST;
   end

   assign self_hit = (sig_row_i == node_row_i) && (sig_col_i == node_col_i);

   // A full buffer still has room when its head leaves this same cycle.
   assign space = (count < 2'd2) || ((count == 2'd2) && msg_ready_i);

   assign grant_bypass = bypass_valid_i && (!sig_valid_i || (last_grant == GRANT_LOCAL));
   assign grant_local  = sig_valid_i && !grant_bypass;

   assign sig_ready_o    = rst_i && grant_local && space;
   assign bypass_ready_o = rst_i && grant_bypass && space;

   assign local_acc  = sig_valid_i && sig_ready_o;
   assign bypass_acc = bypass_valid_i && bypass_ready_o;

   assign push       = bypass_acc || (local_acc && !self_hit);
   assign push_entry = bypass_acc ? {bypass_data_i, bypass_dir_i} : {local_msg, local_dir};

   assign msg_valid_o = (count != 2'd0);
   assign pop         = msg_valid_o && msg_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         last_grant  <= GRANT_LOCAL;
         self_drop_o <= 1'b0;
      end else begin
         self_drop_o <= local_acc && self_hit;
         if (bypass_acc)     last_grant <= GRANT_BYPASS;
         else if (local_acc) last_grant <= GRANT_LOCAL;
      end
   end

   nx_msg_buffer #(
      .WIDTH (ENTRY_WIDTH)
   ) u_buffer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head_entry),
      .count_o (count)
   );

   assign msg_data_o = head_entry[ENTRY_WIDTH-1:2];
   assign msg_dir_o  = head_entry[1:0];

endmodule

// File: tb/tb_nx_msg_encoder.sv
// Directed bench for nx_msg_encoder: routing, arbitration, backpressure, self-drop, reset.
module tb_nx_msg_encoder;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [3:0]  node_row_i, node_col_i;
   logic [3:0]  sig_row_i, sig_col_i;
   logic [2:0]  sig_index_i;
   logic        sig_state_i, sig_valid_i, sig_ready_o;
   logic [31:0] bypass_data_i;
   logic [1:0]  bypass_dir_i;
   logic        bypass_valid_i, bypass_ready_o;
   logic [31:0] msg_data_o;
   logic [1:0]  msg_dir_o;
   logic        msg_valid_o, msg_ready_i, self_drop_o;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   nx_msg_encoder #(
      .STREAM_WIDTH    (32),
      .ADDR_ROW_WIDTH  (4),
      .ADDR_COL_WIDTH  (4),
      .COMMAND_WIDTH   (2),
      .INPUT_IDX_WIDTH (3)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .node_row_i     (node_row_i),
      .node_col_i     (node_col_i),
      .sig_row_i      (sig_row_i),
      .sig_col_i      (sig_col_i),
      .sig_index_i    (sig_index_i),
      .sig_state_i    (sig_state_i),
      .sig_valid_i    (sig_valid_i),
      .sig_ready_o    (sig_ready_o),
      .bypass_data_i  (bypass_data_i),
      .bypass_dir_i   (bypass_dir_i),
      .bypass_valid_i (bypass_valid_i),
      .bypass_ready_o (bypass_ready_o),
      .msg_data_o     (msg_data_o),
      .msg_dir_o      (msg_dir_o),
      .msg_valid_o    (msg_valid_o),
      .msg_ready_i    (msg_ready_i),
      .self_drop_o    (self_drop_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_local(input logic v, input logic [3:0] r, input logic [3:0] c,
                            input logic [2:0] idx, input logic st);
      sig_valid_i = v;
      sig_row_i   = r;
      sig_col_i   = c;
      sig_index_i = idx;
      sig_state_i = st;
   endtask

   task automatic set_bypass(input logic v, input logic [31:0] d, input logic [1:0] dir);
      bypass_valid_i = v;
      bypass_data_i  = d;
      bypass_dir_i   = dir;
   endtask

   task automatic check_out(input string tag, input logic [31:0] d, input logic [1:0] dir);
      check({tag, ".valid"}, 32'(msg_valid_o), 32'd1);
      check({tag, ".data"}, msg_data_o, d);
      check({tag, ".dir"}, 32'(msg_dir_o), 32'(dir));
   endtask

   // Expected words: {row, col, 2'b10, idx, state, 18'b0}
   localparam logic [31:0] M_2_9_I3_S1 = 32'h299C_0000;
   localparam logic [31:0] M_5_9_I0_S0 = 32'h5980_0000;
   localparam logic [31:0] M_5_1_I0_S0 = 32'h5180_0000;
   localparam logic [31:0] M_7_0_I0_S0 = 32'h7080_0000;
   localparam logic [31:0] M_5_9_I1_S0 = 32'h5988_0000;

   initial begin
      rst_i       = 1'b0;
      node_row_i  = 4'd5;
      node_col_i  = 4'd5;
      msg_ready_i = 1'b1;
      set_local(1'b1, 4'd2, 4'd9, 3'd3, 1'b1);
      set_bypass(1'b1, 32'h1234_5678, 2'd3);

      // Reset: outputs idle and readies held low despite valid inputs.
      next_cycle();
      sample();
      check("rst.valid", 32'(msg_valid_o), 32'd0);
      check("rst.sig_ready", 32'(sig_ready_o), 32'd0);
      check("rst.byp_ready", 32'(bypass_ready_o), 32'd0);
      check("rst.self_drop", 32'(self_drop_o), 32'd0);

      // Single local request routed north, visible the cycle after acceptance.
      next_cycle();
      rst_i = 1'b1;
      set_bypass(1'b0, '0, '0);
      sample();
      check("t1.sig_ready", 32'(sig_ready_o), 32'd1);
      check("t1.idle", 32'(msg_valid_o), 32'd0);
      next_cycle();
      set_local(1'b0, '0, '0, '0, 1'b0);
      sample();
      check_out("t1.out", M_2_9_I3_S1, 2'd0);
      next_cycle();
      sample();
      check("t1.drained", 32'(msg_valid_o), 32'd0);

      // Back-to-back local requests: east, west, south.
      next_cycle();
      set_local(1'b1, 4'd5, 4'd9, 3'd0, 1'b0);
      sample();
      check("t2.rdy0", 32'(sig_ready_o), 32'd1);
      next_cycle();
      set_local(1'b1, 4'd5, 4'd1, 3'd0, 1'b0);
      sample();
      check("t2.rdy1", 32'(sig_ready_o), 32'd1);
      check_out("t2.east", M_5_9_I0_S0, 2'd1);
      next_cycle();
      set_local(1'b1, 4'd7, 4'd0, 3'd0, 1'b0);
      sample();
      check_out("t2.west", M_5_1_I0_S0, 2'd3);
      next_cycle();
      set_local(1'b0, '0, '0, '0, 1'b0);
      sample();
      check_out("t2.south", M_7_0_I0_S0, 2'd2);

      // Continuous contention: bypass, local, bypass, local.
      next_cycle();
      set_local(1'b1, 4'd5, 4'd9, 3'd1, 1'b0);
      set_bypass(1'b1, 32'h1234_5678, 2'd3);
      sample();
      check("t3.c1.byp_rdy", 32'(bypass_ready_o), 32'd1);
      check("t3.c1.sig_rdy", 32'(sig_ready_o), 32'd0);
      next_cycle();
      sample();
      check("t3.c2.byp_rdy", 32'(bypass_ready_o), 32'd0);
      check("t3.c2.sig_rdy", 32'(sig_ready_o), 32'd1);
      check_out("t3.c2", 32'h1234_5678, 2'd3);
      next_cycle();
      sample();
      check("t3.c3.byp_rdy", 32'(bypass_ready_o), 32'd1);
      check_out("t3.c3", M_5_9_I1_S0, 2'd1);
      next_cycle();
      sample();
      check("t3.c4.sig_rdy", 32'(sig_ready_o), 32'd1);
      check_out("t3.c4", 32'h1234_5678, 2'd3);
      next_cycle();
      set_local(1'b0, '0, '0, '0, 1'b0);
      set_bypass(1'b0, '0, '0);
      sample();
      check_out("t3.c5", M_5_9_I1_S0, 2'd1);
      next_cycle();
      sample();
      check("t3.drained", 32'(msg_valid_o), 32'd0);

      // Backpressure: two fit, third waits until the output drains.
      next_cycle();
      msg_ready_i = 1'b0;
      set_bypass(1'b1, 32'hAAAA_0001, 2'd0);
      sample();
      check("t4.b1.rdy", 32'(bypass_ready_o), 32'd1);
      next_cycle();
      set_bypass(1'b1, 32'hBBBB_0002, 2'd1);
      sample();
      check("t4.b2.rdy", 32'(bypass_ready_o), 32'd1);
      next_cycle();
      set_bypass(1'b1, 32'hCCCC_0003, 2'd2);
      sample();
      check("t4.b3.blocked", 32'(bypass_ready_o), 32'd0);
      check_out("t4.hold", 32'hAAAA_0001, 2'd0);
      next_cycle();
      msg_ready_i = 1'b1;
      sample();
      check("t4.b3.rdy", 32'(bypass_ready_o), 32'd1);
      check_out("t4.o1", 32'hAAAA_0001, 2'd0);
      next_cycle();
      set_bypass(1'b0, '0, '0);
      sample();
      check_out("t4.o2", 32'hBBBB_0002, 2'd1);
      next_cycle();
      sample();
      check_out("t4.o3", 32'hCCCC_0003, 2'd2);
      next_cycle();
      sample();
      check("t4.drained", 32'(msg_valid_o), 32'd0);

      // Self-addressed local request is consumed and flagged, never emitted.
      next_cycle();
      set_local(1'b1, 4'd5, 4'd5, 3'd2, 1'b1);
      sample();
      check("t5.rdy", 32'(sig_ready_o), 32'd1);
      check("t5.no_drop_yet", 32'(self_drop_o), 32'd0);
      next_cycle();
      set_local(1'b0, '0, '0, '0, 1'b0);
      sample();
      check("t5.drop", 32'(self_drop_o), 32'd1);
      check("t5.no_valid", 32'(msg_valid_o), 32'd0);
      next_cycle();
      sample();
      check("t5.drop_end", 32'(self_drop_o), 32'd0);
      check("t5.no_valid2", 32'(msg_valid_o), 32'd0);

      // Reset with a full buffer, then confirm occupancy restarts at zero.
      next_cycle();
      msg_ready_i = 1'b0;
      set_bypass(1'b1, 32'hDDDD_0004, 2'd0);
      next_cycle();
      set_bypass(1'b1, 32'hEEEE_0005, 2'd1);
      next_cycle();
      rst_i = 1'b0;
      sample();
      check("t6.full_before", 32'(msg_valid_o), 32'd1);
      check("t6.rst_byp_rdy", 32'(bypass_ready_o), 32'd0);
      next_cycle();
      rst_i = 1'b1;
      set_bypass(1'b0, '0, '0);
      sample();
      check("t6.after_rst", 32'(msg_valid_o), 32'd0);
      next_cycle();
      set_local(1'b1, 4'd2, 4'd9, 3'd3, 1'b1);
      sample();
      check("t6.r1.rdy", 32'(sig_ready_o), 32'd1);
      next_cycle();
      set_local(1'b1, 4'd7, 4'd0, 3'd0, 1'b0);
      sample();
      check_out("t6.head", M_2_9_I3_S1, 2'd0);
      check("t6.r2.rdy", 32'(sig_ready_o), 32'd1);
      next_cycle();
      set_local(1'b1, 4'd5, 4'd9, 3'd0, 1'b0);
      sample();
      check("t6.r3.blocked", 32'(sig_ready_o), 32'd0);
      next_cycle();
      set_local(1'b0, '0, '0, '0, 1'b0);
      msg_ready_i = 1'b1;
      sample();
      check_out("t6.o1", M_2_9_I3_S1, 2'd0);
      next_cycle();
      sample();
      check_out("t6.o2", M_7_0_I0_S0, 2'd2);
      next_cycle();
      sample();
      check("t6.drained", 32'(msg_valid_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
